level_sequencer: RTL and testbench



---
 rtl/game_pkg.sv | 34 +++
 rtl/level_sequencer_if.sv | 27 ++
 rtl/platform_mover.sv | 52 +++++
 rtl/level_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_level_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared game-flow definitions: state encoding, playfield boundaries,
// platform reset positions and the platform step rule.
package game_pkg;

  typedef enum logic [2:0] {
    ST_TITLE = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_FALL  = 3'd4,
    ST_WIN   = 3'd5,
    ST_OVER  = 3'd6
  } state_e;

  localparam logic [9:0] LEFT_BOUNDARY  = 10'd13;
  localparam logic [9:0] RIGHT_BOUNDARY = 10'd627;
  localparam logic [9:0] FLOOR_W        = 10'd20;

  localparam logic [9:0] PLAT0_RESET_X  = 10'd627;
  localparam logic [9:0] PLAT1_RESET_X  = 10'd73;

  // One platform step; leftward platforms may land below LEFT_BOUNDARY
  // (e.g. 7) for one period before wrapping to the right edge.
  function automatic logic [9:0] plat_next(input logic [9:0] x, input logic dir_right);
    logic [9:0] nx;
    if (dir_right) begin
      nx = (x < RIGHT_BOUNDARY) ? x + FLOOR_W : LEFT_BOUNDARY;
    end else begin
      nx = (x > LEFT_BOUNDARY) ? x - FLOOR_W : RIGHT_BOUNDARY;
    end
    return nx;
  endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Bundle between the level sequencer and its neighbours (input/debounce,
// player physics, floor/VGA pipeline). The sequencer takes the slave side.
interface level_sequencer_if;
  logic       frame_tick;
  logic       start;
  logic       skip;
  logic [9:0] dope_x;
  logic [9:0] dope_y;
  logic       grounded;
  logic [3:0] level;
  logic       freeze;
  logic       spawn;
  logic [1:0] lives;
  logic [9:0] plat0_x;
  logic [9:0] plat1_x;
  logic [2:0] state_code;

  modport master (
    output frame_tick, start, skip, dope_x, dope_y, grounded,
    input  level, freeze, spawn, lives, plat0_x, plat1_x, state_code
  );

  modport slave (
    input  frame_tick, start, skip, dope_x, dope_y, grounded,
    output level, freeze, spawn, lives, plat0_x, plat1_x, state_code
  );
endinterface

// File: rtl/platform_mover.sv
// Moving platform: steps its x position once every PERIOD enabled frame
// ticks, in the direction given by DIR_RIGHT; reload snaps back to RESET_X.
module platform_mover
  import game_pkg::*;
#(
  parameter int unsigned PERIOD    = 4,
  parameter bit          DIR_RIGHT = 1'b0,
  parameter logic [9:0]  RESET_X   = PLAT0_RESET_X
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_en_i,
  input  logic       reload_i,
  output logic [9:0] x_o
);

  localparam logic [7:0] PERIOD_C = 8'(PERIOD);

  logic [7:0] cnt_q, cnt_d;
  logic [9:0] x_q, x_d;

  // Tick counting and position step; reload wins over a step.
  always_comb begin
    cnt_d = cnt_q;
    x_d   = x_q;
    if (reload_i) begin
      cnt_d = '0;
      x_d   = RESET_X;
    end else if (step_en_i) begin
      if (cnt_q + 8'd1 == PERIOD_C) begin
        cnt_d = '0;
        x_d   = plat_next(x_q, DIR_RIGHT);
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Position and tick counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      x_q   <= RESET_X;
    end else begin
      cnt_q <= cnt_d;
      x_q   <= x_d;
    end
  end

  assign x_o = x_q;

endmodule

// File: rtl/level_sequencer.sv
// Game-flow controller: title/load/play/clear/fall/win/over sequencing,
// level and lives bookkeeping, and the two frame-stepped moving platforms.
// Optional feature macro: LEVEL_SKIP_EN (skip press in PLAY forces CLEAR).
module level_sequencer
  import game_pkg::*;
#(
  parameter int unsigned NUM_LEVELS   = 9,
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned CLEAR_FRAMES = 60,
  parameter int unsigned FALL_FRAMES  = 45,
  parameter int unsigned FALL_Y       = 470,
  parameter int unsigned GOAL_X0      = 560,
  parameter int unsigned GOAL_X1      = 627,
  parameter int unsigned P0_FRAMES    = 4,
  parameter int unsigned P1_FRAMES    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  level_sequencer_if.slave  bus
);

  localparam logic [3:0] LAST_LEVEL = 4'(NUM_LEVELS);
  localparam logic [1:0] LIVES_C    = 2'(LIVES_INIT);
  localparam logic [7:0] CLEAR_C    = 8'(CLEAR_FRAMES);
  localparam logic [7:0] FALL_C     = 8'(FALL_FRAMES);
  localparam logic [9:0] FALL_Y_C   = 10'(FALL_Y);
  localparam logic [9:0] GOAL_X0_C  = 10'(GOAL_X0);
  localparam logic [9:0] GOAL_X1_C  = 10'(GOAL_X1);

  state_e     state_q, state_d;
  logic [3:0] level_q, level_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_inc;
  logic       freeze_q, spawn_q;
  logic       start_q, start_prev_q;
  logic       start_press, skip_press;
  logic       fallen, at_goal;
  logic       plat_step, plat_reload;
  logic [9:0] plat0_x, plat1_x;

  // Start button sampling; a press is the rising edge of the sampled copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      start_q      <= bus.start;
      start_prev_q <= start_q;
    end
  end

  assign start_press = start_q & ~start_prev_q;

`ifdef LEVEL_SKIP_EN
  logic skip_q, skip_prev_q;

  // Skip button sampling, same edge detection as start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skip_q      <= 1'b0;
      skip_prev_q <= 1'b0;
    end else begin
      skip_q      <= bus.skip;
      skip_prev_q <= skip_q;
    end
  end

  assign skip_press = skip_q & ~skip_prev_q;
`else
  assign skip_press = 1'b0;
`endif

  assign fallen  = (bus.dope_y >= FALL_Y_C);
  assign at_goal = bus.grounded && (bus.dope_x >= GOAL_X0_C) && (bus.dope_x < GOAL_X1_C);
  assign cnt_inc = cnt_q + 8'd1;

  // Next-state, level, lives and frame-counter logic.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    lives_d = lives_q;
    cnt_d   = bus.frame_tick ? cnt_inc : cnt_q;
    unique case (state_q)
      ST_TITLE: begin
        if (start_press) begin
          lives_d = LIVES_C;
          level_d = 4'd1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_PLAY;
      ST_PLAY: begin
        if (fallen) begin
          state_d = ST_FALL;
        end else if (at_goal || skip_press) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (bus.frame_tick && cnt_inc == CLEAR_C) begin
          if (level_q == LAST_LEVEL) begin
            state_d = ST_WIN;
          end else begin
            level_d = level_q + 4'd1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_FALL: begin
        if (bus.frame_tick && cnt_inc == FALL_C) begin
          lives_d = lives_q - 2'd1;
          state_d = (lives_q == 2'd1) ? ST_OVER : ST_LOAD;
        end
      end
      ST_WIN, ST_OVER: begin
        if (start_press) begin
          level_d = '0;
          state_d = ST_TITLE;
        end
      end
      default: state_d = ST_TITLE;
    endcase
    // Every state entry restarts the frame count.
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_TITLE;
      level_q  <= '0;
      lives_q  <= '0;
      cnt_q    <= '0;
      freeze_q <= 1'b1;
      spawn_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      lives_q  <= lives_d;
      cnt_q    <= cnt_d;
      freeze_q <= (state_d != ST_PLAY);
      spawn_q  <= (state_d == ST_LOAD);
    end
  end

  // Step decided on the current state so a tick coinciding with a PLAY exit
  // still moves the platforms; reload lands together with the LOAD state.
  assign plat_step   = bus.frame_tick && (state_q == ST_PLAY);
  assign plat_reload = (state_d == ST_LOAD);

  platform_mover #(
    .PERIOD    (P0_FRAMES),
    .DIR_RIGHT (1'b0),
    .RESET_X   (PLAT0_RESET_X)
  ) u_plat0 (
    .clk       (clk),
    .rst_n     (reset_n),
    .step_en_i (plat_step),
    .reload_i  (plat_reload),
    .x_o       (plat0_x)
  );

  platform_mover #(
    .PERIOD    (P1_FRAMES),
    .DIR_RIGHT (1'b1),
    .RESET_X   (PLAT1_RESET_X)
  ) u_plat1 (
    .clk       (clk),
    .rst_n     (reset_n),
    .step_en_i (plat_step),
    .reload_i  (plat_reload),
    .x_o       (plat1_x)
  );

  assign bus.level      = level_q;
  assign bus.freeze     = freeze_q;
  assign bus.spawn      = spawn_q;
  assign bus.lives      = lives_q;
  assign bus.plat0_x    = plat0_x;
  assign bus.plat1_x    = plat1_x;
  assign bus.state_code = state_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Scoreboard bench for level_sequencer: stimulus pushes expected state and
// platform snapshots; a negedge monitor pops one whenever the DUT changes.
module tb_level_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  level_sequencer_if bus();

  level_sequencer #(
    .NUM_LEVELS   (9),
    .LIVES_INIT   (3),
    .CLEAR_FRAMES (60),
    .FALL_FRAMES  (45),
    .FALL_Y       (470),
    .GOAL_X0      (560),
    .GOAL_X1      (627),
    .P0_FRAMES    (4),
    .P1_FRAMES    (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        mon_en   = 1'b0;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] lvl;
    logic [1:0] lives;
    logic       spawn;
    logic       freeze;
  } st_exp_t;

  typedef struct packed {
    logic [9:0] p0;
    logic [9:0] p1;
  } pl_exp_t;

  st_exp_t st_q[$];
  pl_exp_t pl_q[$];

  logic [9:0]  m_p0 = 10'd627;
  logic [9:0]  m_p1 = 10'd73;
  int unsigned m_c0 = 0;
  int unsigned m_c1 = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_state(input logic [2:0] st, input logic [3:0] lvl, input logic [1:0] lv,
                           input logic sp, input logic fr);
    st_q.push_back('{st, lvl, lv, sp, fr});
  endtask

  task automatic exp_plat(input logic [9:0] p0, input logic [9:0] p1);
    if (p0 != m_p0 || p1 != m_p1) pl_q.push_back('{p0, p1});
    m_p0 = p0;
    m_p1 = p1;
  endtask

  task automatic plat_reload();
    m_c0 = 0;
    m_c1 = 0;
    exp_plat(10'd627, 10'd73);
  endtask

  // Reference platform behaviour for one PLAY frame tick.
  task automatic plat_model_tick();
    logic [9:0] n0, n1;
    n0 = m_p0;
    n1 = m_p1;
    m_c0++;
    if (m_c0 == 4) begin
      m_c0 = 0;
      n0 = (m_p0 > 10'd13) ? m_p0 - 10'd20 : 10'd627;
    end
    m_c1++;
    if (m_c1 == 2) begin
      m_c1 = 0;
      n1 = (m_p1 < 10'd627) ? m_p1 + 10'd20 : 10'd13;
    end
    exp_plat(n0, n1);
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    cyc(1);
    bus.frame_tick = 1'b0;
    cyc(1);
  endtask

  task automatic play_tick();
    plat_model_tick();
    tick();
  endtask

  task automatic press_start();
    bus.start = 1'b1;
    cyc(3);
    bus.start = 1'b0;
    cyc(1);
  endtask

  task automatic start_game();
    exp_state(3'd1, 4'd1, 2'd3, 1'b1, 1'b1);
    plat_reload();
    exp_state(3'd2, 4'd1, 2'd3, 1'b0, 1'b0);
    press_start();
  endtask

  task automatic reach_goal();
    bus.dope_x   = 10'd600;
    bus.grounded = 1'b1;
    cyc(1);
    bus.dope_x   = 10'd100;
    bus.grounded = 1'b0;
    cyc(1);
  endtask

  task automatic clear_run(input logic [3:0] lvl, input logic [1:0] lv);
    exp_state(3'd3, lvl, lv, 1'b0, 1'b1);
    if (lvl == 4'd9) begin
      exp_state(3'd5, lvl, lv, 1'b0, 1'b1);
    end else begin
      exp_state(3'd1, lvl + 4'd1, lv, 1'b1, 1'b1);
      plat_reload();
      exp_state(3'd2, lvl + 4'd1, lv, 1'b0, 1'b0);
    end
    reach_goal();
    for (int t = 1; t <= 60; t++) begin
      tick();
      if (t == 59 && lvl == 4'd1) check("clear_tick59_still_clear", bus.state_code, 3);
    end
  endtask

  task automatic fall_run(input logic [1:0] lv);
    exp_state(3'd4, 4'd1, lv, 1'b0, 1'b1);
    if (lv == 2'd1) begin
      exp_state(3'd6, 4'd1, 2'd0, 1'b0, 1'b1);
    end else begin
      exp_state(3'd1, 4'd1, lv - 2'd1, 1'b1, 1'b1);
      plat_reload();
      exp_state(3'd2, 4'd1, lv - 2'd1, 1'b0, 1'b0);
    end
    bus.dope_y = 10'd470;
    cyc(1);
    bus.dope_y = 10'd100;
    cyc(1);
    repeat (45) tick();
  endtask

  // Monitor: any change of state or platform position consumes one expectation.
  initial begin : monitor
    logic [2:0] prev_st;
    logic [9:0] prev_p0, prev_p1;
    st_exp_t    se;
    pl_exp_t    pe;
    prev_st = '0;
    prev_p0 = '0;
    prev_p1 = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.state_code != prev_st) begin
          if (st_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL state_unexpected: got state %0d expected no change (t=%0t)", bus.state_code, $time);
          end else begin
            se = st_q.pop_front();
            check("mon_state", bus.state_code, se.st);
            check("mon_level", bus.level, se.lvl);
            check("mon_lives", bus.lives, se.lives);
            check("mon_spawn", bus.spawn, se.spawn);
            check("mon_freeze", bus.freeze, se.freeze);
          end
        end
        if (bus.plat0_x != prev_p0 || bus.plat1_x != prev_p1) begin
          if (pl_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL plat_unexpected: got %0d/%0d expected no change (t=%0t)", bus.plat0_x, bus.plat1_x, $time);
          end else begin
            pe = pl_q.pop_front();
            check("mon_plat0_x", bus.plat0_x, pe.p0);
            check("mon_plat1_x", bus.plat1_x, pe.p1);
          end
        end
      end
      prev_st = bus.state_code;
      prev_p0 = bus.plat0_x;
      prev_p1 = bus.plat1_x;
    end
  end

  initial begin : stimulus
    reset_n        = 1'b0;
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.skip       = 1'b0;
    bus.dope_x     = 10'd100;
    bus.dope_y     = 10'd100;
    bus.grounded   = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(1);

    check("rst_state", bus.state_code, 0);
    check("rst_level", bus.level, 0);
    check("rst_freeze", bus.freeze, 1);
    check("rst_spawn", bus.spawn, 0);
    check("rst_lives", bus.lives, 0);
    check("rst_plat0_x", bus.plat0_x, 627);
    check("rst_plat1_x", bus.plat1_x, 73);
    mon_en = 1'b1;
    cyc(1);

    start_game();
    check("start_level", bus.level, 1);
    check("start_lives", bus.lives, 3);

    for (int i = 1; i <= 128; i++) begin
      play_tick();
      if (i == 8) begin
        check("plat0_after_8", bus.plat0_x, 587);
        check("plat1_after_8", bus.plat1_x, 153);
      end
      if (i == 54)  check("plat1_at_613", bus.plat1_x, 613);
      if (i == 56)  check("plat1_at_633", bus.plat1_x, 633);
      if (i == 58)  check("plat1_wrap_13", bus.plat1_x, 13);
      if (i == 124) check("plat0_at_7", bus.plat0_x, 7);
      if (i == 128) check("plat0_wrap_627", bus.plat0_x, 627);
    end

    bus.grounded = 1'b1;
    bus.dope_x   = 10'd627;
    cyc(1);
    check("goal_x1_exclusive", bus.state_code, 2);
    bus.dope_x = 10'd559;
    cyc(1);
    check("goal_below_x0", bus.state_code, 2);
    bus.dope_x   = 10'd600;
    bus.grounded = 1'b0;
    cyc(1);
    check("goal_not_grounded", bus.state_code, 2);
    bus.dope_x = 10'd100;
    bus.dope_y = 10'd469;
    cyc(1);
    check("fall_y_469", bus.state_code, 2);
    bus.dope_y = 10'd100;
    cyc(1);

    repeat (3) play_tick();
    plat_model_tick();
    exp_state(3'd4, 4'd1, 2'd3, 1'b0, 1'b1);
    bus.dope_y     = 10'd470;
    bus.dope_x     = 10'd600;
    bus.grounded   = 1'b1;
    bus.frame_tick = 1'b1;
    cyc(1);
    bus.frame_tick = 1'b0;
    bus.dope_y     = 10'd100;
    bus.dope_x     = 10'd100;
    bus.grounded   = 1'b0;
    check("fall_priority", bus.state_code, 4);
    check("exit_tick_steps_plat0", bus.plat0_x, 607);
    cyc(1);
    exp_state(3'd1, 4'd1, 2'd2, 1'b1, 1'b1);
    plat_reload();
    exp_state(3'd2, 4'd1, 2'd2, 1'b0, 1'b0);
    repeat (44) tick();
    check("fall_tick44_still_fall", bus.state_code, 4);
    tick();
    check("fall_lives", bus.lives, 2);
    check("fall_level", bus.level, 1);

    for (int l = 1; l <= 9; l++) clear_run(4'(l), 2'd2);
    check("win_state", bus.state_code, 5);
    check("win_level", bus.level, 9);

    exp_state(3'd0, 4'd0, 2'd2, 1'b0, 1'b1);
    bus.start = 1'b1;
    cyc(3);
    check("win_to_title", bus.state_code, 0);
    check("title_level", bus.level, 0);
    cyc(5);
    check("held_start_no_restart", bus.state_code, 0);
    bus.start = 1'b0;
    cyc(2);

    start_game();
    fall_run(2'd3);
    fall_run(2'd2);
    fall_run(2'd1);
    check("over_state", bus.state_code, 6);
    check("over_lives", bus.lives, 0);
    exp_state(3'd0, 4'd0, 2'd0, 1'b0, 1'b1);
    press_start();
    check("over_to_title", bus.state_code, 0);

    start_game();
    repeat (4) play_tick();
    exp_state(3'd3, 4'd1, 2'd3, 1'b0, 1'b1);
    reach_goal();
    repeat (30) tick();
    exp_state(3'd0, 4'd0, 2'd0, 1'b0, 1'b1);
    plat_reload();
    reset_n = 1'b0;
    #1;
    check("midclear_rst_state", bus.state_code, 0);
    check("midclear_rst_plat0", bus.plat0_x, 627);
    check("midclear_rst_plat1", bus.plat1_x, 73);
    check("midclear_rst_freeze", bus.freeze, 1);
    check("midclear_rst_level", bus.level, 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(3);

    check("state_queue_leftover", st_q.size(), 0);
    check("plat_queue_leftover", pl_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
